// File: rtl/cpu_mmu_pkg.sv
// rtl/cpu_mmu_pkg.sv - shared state encoding, PTE layout and timeout defaults for the MMU refill controller
package cpu_mmu_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH0 = 3'd1,
        ST_FETCH1 = 3'd2,
        ST_WRITE  = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    localparam int PTE_WPM = 15;
    localparam int PTE_RPM = 14;
    localparam int PTE_FPM = 13;
    localparam int PPN_W   = 14;

    localparam int              TMO_W          = 8;
    localparam logic [TMO_W-1:0] TMO_CYCLES_DEF = 8'd255;

    // A page with no write, read or fetch permission is treated as a fault.
    function automatic logic pte_permits(input logic [15:0] word0);
        return word0[PTE_WPM] | word0[PTE_RPM] | word0[PTE_FPM];
    endfunction

endpackage

// File: rtl/cpu_mmu_refill_tmo.sv
// rtl/cpu_mmu_refill_tmo.sv - 8-bit page-table bus timeout counter with clear, enable and expire
module cpu_mmu_refill_tmo
    import cpu_mmu_pkg::*;
#(
    parameter logic [TMO_W-1:0] TMO_CYCLES = TMO_CYCLES_DEF
) (
    input  logic sysclk,
    input  logic sys_rst,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam logic [TMO_W-1:0] LAST = TMO_CYCLES - 1'b1;

    logic [TMO_W-1:0] cnt_q;

    always_ff @(posedge sysclk or posedge sys_rst) begin
        if (sys_rst) begin
            cnt_q <= '0;
        end else if (clear) begin
            cnt_q <= '0;
        end else if (enable) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // Fires on the last waiting cycle so the abort lands TMO_CYCLES after the clear.
    assign expire = enable & ~clear & (cnt_q == LAST);

endmodule

// File: rtl/cpu_mmu_refill_ctl.sv
// rtl/cpu_mmu_refill_ctl.sv - MMU way-miss refill FSM: PTE fetch, permission check, victim tag write (MMU_REFILL_TMO_EN enables bus timeout)
module cpu_mmu_refill_ctl
    import cpu_mmu_pkg::*;
#(
    parameter logic [TMO_W-1:0] TMO_CYCLES = TMO_CYCLES_DEF
) (
    input  logic             sysclk,
    input  logic             sys_rst,
    input  logic             req_i,
    input  logic             HIT0_n,
    input  logic             HIT1_n,
    input  logic [5:0]       lpn_i,
    input  logic [15:0]      pt_base_i,
    output logic             pt_req_o,
    output logic [15:0]      pt_addr_o,
    input  logic             pt_ack_i,
    input  logic [15:0]      pt_data_i,
    output logic             tag_we_o,
    output logic             tag_way_o,
    output logic [PPN_W-1:0] tag_data_o,
    output logic             hit_o,
    output logic             fault_o,
    output logic             tmo_o,
    output logic             busy_o
);

    state_t            state_q, state_d;
    logic              in_fetch, tmo_expire, any_hit, permit;
    logic              way_q, victim_q, fault_q, tmo_q;
    logic [15:0]       addr_q;
    logic [PPN_W-1:0]  ppn_q;

    assign any_hit  = ~HIT0_n | ~HIT1_n;
    assign permit   = pte_permits(pt_data_i);
    assign in_fetch = (state_q == ST_FETCH0) || (state_q == ST_FETCH1);

`ifdef MMU_REFILL_TMO_EN
    cpu_mmu_refill_tmo #(
        .TMO_CYCLES (TMO_CYCLES)
    ) u_tmo (
        .sysclk (sysclk),
        .sys_rst(sys_rst),
        .clear  (~in_fetch | pt_ack_i),
        .enable (in_fetch),
        .expire (tmo_expire)
    );
`else
    logic unused_tmo_cfg;
    assign unused_tmo_cfg = ^TMO_CYCLES;
    assign tmo_expire     = 1'b0;
`endif

    always_ff @(posedge sysclk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (req_i) begin
                    state_d = any_hit ? ST_DONE : ST_FETCH0;
                end
            end
            ST_FETCH0: begin
                if (pt_ack_i) begin
                    state_d = permit ? ST_FETCH1 : ST_IDLE;
                end else if (tmo_expire) begin
                    state_d = ST_IDLE;
                end
            end
            ST_FETCH1: begin
                if (pt_ack_i) begin
                    state_d = ST_WRITE;
                end else if (tmo_expire) begin
                    state_d = ST_IDLE;
                end
            end
            ST_WRITE: state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // The word address is held in a flop so pt_addr_o is stable while waiting for ack.
    always_ff @(posedge sysclk or posedge sys_rst) begin
        if (sys_rst) begin
            way_q    <= 1'b0;
            victim_q <= 1'b0;
            fault_q  <= 1'b0;
            tmo_q    <= 1'b0;
            addr_q   <= '0;
            ppn_q    <= '0;
        end else begin
            fault_q <= (state_q == ST_FETCH0) && pt_ack_i && !permit;
            tmo_q   <= tmo_expire;
            case (state_q)
                ST_IDLE: begin
                    if (req_i) begin
                        way_q <= any_hit ? HIT0_n : victim_q;
                        if (!any_hit) begin
                            addr_q <= pt_base_i + {9'd0, lpn_i, 1'b0};
                        end
                    end
                end
                ST_FETCH0: begin
                    if (pt_ack_i && permit) begin
                        addr_q <= addr_q + 16'd1;
                    end
                end
                ST_FETCH1: begin
                    if (pt_ack_i) begin
                        ppn_q <= pt_data_i[PPN_W-1:0];
                    end
                end
                ST_WRITE: victim_q <= ~victim_q;
                default: ;
            endcase
        end
    end

    always_comb begin
        pt_req_o   = in_fetch;
        pt_addr_o  = addr_q;
        tag_we_o   = (state_q == ST_WRITE);
        tag_way_o  = way_q;
        tag_data_o = ppn_q;
        hit_o      = (state_q == ST_DONE);
        fault_o    = fault_q;
        tmo_o      = tmo_q;
        busy_o     = (state_q != ST_IDLE);
    end

endmodule
